// File: rtl/camera_power_seq.sv
// -----------------------------------------------------------------------------
// camera_power_seq
//
// Camera power-up / reset sequencer in the 25 MHz camera clock domain.
// It gates XCLK to the sensor, releases PWDN and RESET_N in timed phases,
// fires a one-cycle request at the SCCB register-init block, then waits
// (bounded by a timeout) for that block to report completion. `ready` is
// the enable for the downstream capture / ISP stages.
//
// Optional build macro: CAM_POWER_SEQ_RETRY_EN
//   defined   : an init timeout triggers up to MAX_RETRY full repower
//               attempts before the sequencer gives up in FAULT.
//   undefined : an init timeout goes straight to FAULT (MAX_RETRY absent).
//
// Ports:
//   clk        in   camera-domain clock
//   rst        in   synchronous active-high reset
//   start      in   level; starts the sequence from IDLE, READY or FAULT
//   stop       in   level; forces IDLE (sensor powered down), beats start
//   init_done  in   completion from SCCB init block, sampled in WAIT_INIT only
//   xclk_en    out  XCLK output buffer enable
//   cam_pwdn   out  sensor power-down pin (1 = powered down)
//   cam_rst_n  out  sensor reset pin (active low)
//   init_req   out  single-cycle request to the SCCB init block
//   busy       out  sequence in progress
//   ready      out  sensor powered and initialised
//   fault      out  init timed out; sensor powered down
// -----------------------------------------------------------------------------
module camera_power_seq #(
    parameter int unsigned PWDN_CYCLES   = 25000,
    parameter int unsigned RST_CYCLES    = 25000,
    parameter int unsigned SETTLE_CYCLES = 500000,
    parameter int unsigned INIT_TIMEOUT  = 2500000
`ifdef CAM_POWER_SEQ_RETRY_EN
    ,
    parameter int unsigned MAX_RETRY     = 2
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic stop,
    input  logic init_done,
    output logic xclk_en,
    output logic cam_pwdn,
    output logic cam_rst_n,
    output logic init_req,
    output logic busy,
    output logic ready,
    output logic fault
);

    typedef enum logic [2:0] {
        IDLE,
        PWDN,
        RESET,
        SETTLE,
        INIT_REQ,
        WAIT_INIT,
        READY,
        FAULT
    } state_t;

    // The counter is loaded with N-1 on entry and the state exits on the
    // edge after it reaches zero, so each timed state lasts exactly N cycles.
    localparam logic [23:0] PWDN_LOAD    = 24'(PWDN_CYCLES - 1);
    localparam logic [23:0] RST_LOAD     = 24'(RST_CYCLES - 1);
    localparam logic [23:0] SETTLE_LOAD  = 24'(SETTLE_CYCLES - 1);
    localparam logic [23:0] TIMEOUT_LOAD = 24'(INIT_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;

    logic xclk_en_q,   xclk_en_d;
    logic cam_pwdn_q,  cam_pwdn_d;
    logic cam_rst_n_q, cam_rst_n_d;
    logic init_req_q,  init_req_d;
    logic busy_q,      busy_d;
    logic ready_q,     ready_d;
    logic fault_q,     fault_d;

`ifdef CAM_POWER_SEQ_RETRY_EN
    localparam logic [3:0] MAX_RETRY_W = 4'(MAX_RETRY);
    logic [3:0] retry_q, retry_d;
`endif

    // Next-state / counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef CAM_POWER_SEQ_RETRY_EN
        retry_d = retry_q;
`endif
        case (state_q)
            IDLE, READY, FAULT: begin
                if (start) begin
                    state_d = PWDN;
                    cnt_d   = PWDN_LOAD;
`ifdef CAM_POWER_SEQ_RETRY_EN
                    retry_d = '0;
`endif
                end
            end
            PWDN: begin
                if (cnt_q == '0) begin
                    state_d = RESET;
                    cnt_d   = RST_LOAD;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            RESET: begin
                if (cnt_q == '0) begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = INIT_REQ;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            INIT_REQ: begin
                state_d = WAIT_INIT;
                cnt_d   = TIMEOUT_LOAD;
            end
            WAIT_INIT: begin
                // init_done is checked first so a completion in the last
                // timeout cycle still counts as success.
                if (init_done) begin
                    state_d = READY;
                end else if (cnt_q == '0) begin
`ifdef CAM_POWER_SEQ_RETRY_EN
                    if (retry_q < MAX_RETRY_W) begin
                        state_d = PWDN;
                        cnt_d   = PWDN_LOAD;
                        retry_d = retry_q + 4'd1;
                    end else begin
                        state_d = FAULT;
                    end
`else
                    state_d = FAULT;
`endif
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
`ifdef CAM_POWER_SEQ_RETRY_EN
            retry_d = '0;
`endif
        end
    end

    // Outputs are decoded from the next state so the registered pins change
    // on the same edge as the state register.
    always_comb begin
        xclk_en_d   = 1'b0;
        cam_pwdn_d  = 1'b1;
        cam_rst_n_d = 1'b0;
        init_req_d  = 1'b0;
        busy_d      = 1'b0;
        ready_d     = 1'b0;
        fault_d     = 1'b0;
        case (state_d)
            PWDN: begin
                xclk_en_d = 1'b1;
                busy_d    = 1'b1;
            end
            RESET: begin
                xclk_en_d  = 1'b1;
                cam_pwdn_d = 1'b0;
                busy_d     = 1'b1;
            end
            SETTLE, WAIT_INIT: begin
                xclk_en_d   = 1'b1;
                cam_pwdn_d  = 1'b0;
                cam_rst_n_d = 1'b1;
                busy_d      = 1'b1;
            end
            INIT_REQ: begin
                xclk_en_d   = 1'b1;
                cam_pwdn_d  = 1'b0;
                cam_rst_n_d = 1'b1;
                init_req_d  = 1'b1;
                busy_d      = 1'b1;
            end
            READY: begin
                xclk_en_d   = 1'b1;
                cam_pwdn_d  = 1'b0;
                cam_rst_n_d = 1'b1;
                ready_d     = 1'b1;
            end
            FAULT: begin
                fault_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            xclk_en_q   <= 1'b0;
            cam_pwdn_q  <= 1'b1;
            cam_rst_n_q <= 1'b0;
            init_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
`ifdef CAM_POWER_SEQ_RETRY_EN
            retry_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            xclk_en_q   <= xclk_en_d;
            cam_pwdn_q  <= cam_pwdn_d;
            cam_rst_n_q <= cam_rst_n_d;
            init_req_q  <= init_req_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
`ifdef CAM_POWER_SEQ_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    assign xclk_en   = xclk_en_q;
    assign cam_pwdn  = cam_pwdn_q;
    assign cam_rst_n = cam_rst_n_q;
    assign init_req  = init_req_q;
    assign busy      = busy_q;
    assign ready     = ready_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_camera_power_seq.sv
// -----------------------------------------------------------------------------
// tb_camera_power_seq
//
// Directed bench for camera_power_seq with PWDN=4, RST=3, SETTLE=5,
// TIMEOUT=10. Edge numbers below count from the edge that samples start.
// Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_camera_power_seq;

    logic clk = 1'b0;
    logic rst, start, stop, init_done;
    logic xclk_en, cam_pwdn, cam_rst_n, init_req, busy, ready, fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    camera_power_seq #(
        .PWDN_CYCLES  (4),
        .RST_CYCLES   (3),
        .SETTLE_CYCLES(5),
        .INIT_TIMEOUT (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .init_done(init_done),
        .xclk_en  (xclk_en),
        .cam_pwdn (cam_pwdn),
        .cam_rst_n(cam_rst_n),
        .init_req (init_req),
        .busy     (busy),
        .ready    (ready),
        .fault    (fault)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Outputs expected in IDLE / after reset or stop.
    task automatic chk_idle(input string tag);
        chk({tag, ".xclk_en"},   32'(xclk_en),   32'd0);
        chk({tag, ".cam_pwdn"},  32'(cam_pwdn),  32'd1);
        chk({tag, ".cam_rst_n"}, 32'(cam_rst_n), 32'd0);
        chk({tag, ".init_req"},  32'(init_req),  32'd0);
        chk({tag, ".busy"},      32'(busy),      32'd0);
        chk({tag, ".ready"},     32'(ready),     32'd0);
        chk({tag, ".fault"},     32'(fault),     32'd0);
    endtask

    initial begin
        int pulses;
        int fault_edge;
        int exp_pulses;
        int exp_fault_edge;
        logic exp_xclk23;
        logic xclk23;
        logic saw_req;

`ifdef CAM_POWER_SEQ_RETRY_EN
        exp_pulses     = 3;
        exp_fault_edge = 69;   // three attempts of 23 cycles each
        exp_xclk23     = 1'b1; // retry goes straight back to PWDN
`else
        exp_pulses     = 1;
        exp_fault_edge = 23;   // 12 + 1 + 10
        exp_xclk23     = 1'b0;
`endif

        rst = 1'b1; start = 1'b0; stop = 1'b0; init_done = 1'b0;
        step(); step();
        chk_idle("reset");
        rst = 1'b0;
        step();
        chk_idle("idle_hold");

        // ---------------- basic sequence ----------------
        start = 1'b1;
        step();                                   // edge 0
        start = 1'b0;
        chk("basic.xclk_en@0",  32'(xclk_en),  32'd1);
        chk("basic.cam_pwdn@0", 32'(cam_pwdn), 32'd1);
        chk("basic.busy@0",     32'(busy),     32'd1);
        for (int e = 1; e <= 14; e++) begin
            step();
            chk($sformatf("basic.cam_pwdn@%0d", e),  32'(cam_pwdn),  32'(e < 4));
            chk($sformatf("basic.cam_rst_n@%0d", e), 32'(cam_rst_n), 32'(e >= 7));
            chk($sformatf("basic.init_req@%0d", e),  32'(init_req),  32'(e == 12));
            chk($sformatf("basic.busy@%0d", e),      32'(busy),      32'd1);
            chk($sformatf("basic.ready@%0d", e),     32'(ready),     32'd0);
        end
        init_done = 1'b1;
        step();                                   // edge 15
        init_done = 1'b0;
        chk("basic.ready@15",    32'(ready),    32'd1);
        chk("basic.busy@15",     32'(busy),     32'd0);
        chk("basic.xclk_en@15",  32'(xclk_en),  32'd1);
        chk("basic.cam_pwdn@15", 32'(cam_pwdn), 32'd0);
        step();
        chk("basic.ready_hold",  32'(ready),    32'd1);

        // ---------------- timeout / retry ----------------
        start = 1'b1;
        step();                                   // edge 0
        start = 1'b0;
        pulses = 0;
        fault_edge = -1;
        xclk23 = 1'b0;
        for (int e = 1; e <= 80; e++) begin
            step();
            if (init_req) pulses++;
            if (e == 23) xclk23 = xclk_en;
            if (fault && fault_edge < 0) fault_edge = e;
        end
        chk("timeout.init_req_pulses", 32'(pulses),     32'(exp_pulses));
        chk("timeout.fault_edge",      32'(fault_edge), 32'(exp_fault_edge));
        chk("timeout.xclk_en@23",      32'(xclk23),     32'(exp_xclk23));
        chk("timeout.fault",     32'(fault),     32'd1);
        chk("timeout.xclk_en",   32'(xclk_en),   32'd0);
        chk("timeout.cam_pwdn",  32'(cam_pwdn),  32'd1);
        chk("timeout.cam_rst_n", 32'(cam_rst_n), 32'd0);
        chk("timeout.busy",      32'(busy),      32'd0);

        // ---------------- tie: done in last timeout cycle ----------------
        start = 1'b1;
        step();                                   // edge 0 (from FAULT)
        start = 1'b0;
        chk("tie.fault_cleared@0", 32'(fault), 32'd0);
        for (int e = 1; e <= 22; e++) step();
        chk("tie.busy@22", 32'(busy), 32'd1);
        init_done = 1'b1;                         // 10th WAIT_INIT cycle
        step();                                   // edge 23
        init_done = 1'b0;
        chk("tie.ready@23", 32'(ready), 32'd1);
        chk("tie.fault@23", 32'(fault), 32'd0);

        // ---------------- stop beats start ----------------
        start = 1'b1;
        step();                                   // edge 0 (start held)
        for (int e = 1; e <= 8; e++) step();      // edge 8, inside SETTLE
        chk("prio.cam_rst_n@8", 32'(cam_rst_n), 32'd1);
        stop = 1'b1;
        saw_req = 1'b0;
        step();
        chk_idle("prio.stop");
        for (int e = 0; e < 5; e++) begin
            step();
            if (init_req) saw_req = 1'b1;
        end
        chk("prio.no_init_req", 32'(saw_req), 32'd0);
        chk("prio.busy_idle",   32'(busy),    32'd0);
        stop = 1'b0;
        step();                                   // restart edge 0
        start = 1'b0;
        chk("prio.restart.xclk_en",  32'(xclk_en),  32'd1);
        chk("prio.restart.cam_pwdn", 32'(cam_pwdn), 32'd1);
        chk("prio.restart.busy",     32'(busy),     32'd1);

        // ---------------- reset in WAIT_INIT ----------------
        for (int e = 1; e <= 14; e++) step();     // edge 14, WAIT_INIT
        chk("mid.busy@14",      32'(busy),      32'd1);
        chk("mid.cam_rst_n@14", 32'(cam_rst_n), 32'd1);
        rst = 1'b1;
        step();
        chk_idle("mid.rst");
        rst = 1'b0;
        init_done = 1'b1;                         // late completion
        step(); step();
        init_done = 1'b0;
        chk_idle("mid.late_done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/camera_power_seq.md
Name: camera_power_seq

Overview:
Camera power-up and reset sequencer clocked by the 25 MHz camera clock (50 MHz board clock, PLL output divider 32). It gates XCLK to the sensor and drives the sensor PWDN and RESET_N pins with timed phases. It then issues a one-cycle request to the SCCB register-init block and waits, with a timeout, for that block to finish. Downstream capture and ISP stages use `ready` as their enable.

Parameters:
- PWDN_CYCLES, 25000, cycles PWDN is held high with XCLK running (1 ms at 25 MHz); valid range 1..2^24-1.
- RST_CYCLES, 25000, cycles RESET_N is held low after PWDN release (1 ms); valid range 1..2^24-1.
- SETTLE_CYCLES, 500000, cycles after RESET_N release before the init request (20 ms); valid range 1..2^24-1.
- INIT_TIMEOUT, 2500000, maximum cycles spent waiting for init_done (100 ms); valid range 1..2^24-1.
- MAX_RETRY, 2, repower attempts after a timeout; used only with CAM_POWER_SEQ_RETRY_EN.

Ports:
- clk  input  1  camera-domain clock (PLL output, 25 MHz)
- rst  input  1  synchronous, active-high reset
- start  input  1  level; begins the sequence from IDLE, READY or FAULT
- stop  input  1  level; forces IDLE (sensor powered down); takes priority over start
- init_done  input  1  pulse or level from the SCCB init block; sampled only in WAIT_INIT
- xclk_en  output  1  enable for the XCLK output buffer
- cam_pwdn  output  1  sensor power-down pin (1 = powered down)
- cam_rst_n  output  1  sensor reset pin (active low)
- init_req  output  1  single-cycle pulse to the SCCB init block
- busy  output  1  high in PWDN, RESET, SETTLE, INIT_REQ and WAIT_INIT
- ready  output  1  high in READY
- fault  output  1  high in FAULT

Behaviour:
- Clocking and reset: single clock. All outputs are registered and update on the same edge as the state register.
- Reset values (rst=1, or after stop): state IDLE, xclk_en=0, cam_pwdn=1, cam_rst_n=0, init_req=0, busy=0, ready=0, fault=0. The cycle counter and retry counter are cleared.
- States: IDLE, PWDN, RESET, SETTLE, INIT_REQ, WAIT_INIT, READY, FAULT.
- One 24-bit down-counter is loaded on entry to each timed state. Each timed state lasts exactly its parameter value in cycles.
- IDLE: start=1 -> PWDN.
- PWDN: xclk_en=1, cam_pwdn=1, cam_rst_n=0. After PWDN_CYCLES -> RESET.
- RESET: cam_pwdn=0, cam_rst_n=0. After RST_CYCLES -> SETTLE.
- SETTLE: cam_rst_n=1. After SETTLE_CYCLES -> INIT_REQ.
- INIT_REQ: init_req=1 for exactly one cycle, then unconditionally -> WAIT_INIT.
- WAIT_INIT:
  - init_done=1 -> READY.
  - INIT_TIMEOUT cycles elapsed without init_done -> FAULT.
  - If init_done and timeout expiry coincide, init_done wins (READY).
- READY: xclk_en=1, cam_pwdn=0, cam_rst_n=1, ready=1. Holds until stop, start or rst. start=1 -> PWDN (full repower).
- FAULT: xclk_en=0, cam_pwdn=1, cam_rst_n=0, fault=1. start=1 -> PWDN.
- start held high: in READY or FAULT it retriggers the sequence each time that state is reached. It has no effect inside busy states.
- stop=1 in any state -> IDLE with reset values on the next edge. stop beats start.
- rst mid-sequence: returns to reset values on the next edge. The sensor is immediately powered down and held in reset.
- init_done outside WAIT_INIT is ignored.
- Timing from start sampled at edge k:
  - xclk_en rises at edge k.
  - cam_pwdn falls at k+PWDN_CYCLES.
  - cam_rst_n rises at k+PWDN_CYCLES+RST_CYCLES.
  - init_req rises at k+PWDN_CYCLES+RST_CYCLES+SETTLE_CYCLES and falls one edge later.

Optional Feature:
- Macro: CAM_POWER_SEQ_RETRY_EN.
- Defined: a 4-bit retry counter is cleared on every entry to PWDN from IDLE, READY or FAULT. On WAIT_INIT timeout:
  - if retries < MAX_RETRY: increment the counter and go to PWDN (full repower, xclk_en stays 1);
  - otherwise go to FAULT.
- Not defined: a timeout goes directly to FAULT, and MAX_RETRY is ignored.

Test Plan:
- Bench parameters: P=4, R=3, S=5, T=10 throughout.
- Basic sequence: rst 2 cycles, then start=1 at edge 0 with init_done returned 2 cycles after init_req:
  - xclk_en=1 at edge 0; cam_pwdn=0 at edge 4; cam_rst_n=1 at edge 7; init_req high for edge 12 only;
  - ready=1 at edge 15; busy high over edges 0..14.
- Timeout: init_done never asserted -> fault=1 at edge 23 (12+1+10). xclk_en=0, cam_pwdn=1, cam_rst_n=0.
- Tie: init_done asserted in the 10th WAIT_INIT cycle -> READY, fault stays 0.
- Priority: stop=1 during SETTLE with start=1 -> IDLE and reset values next edge, no init_req pulse. Release stop -> sequence restarts from PWDN.
- Mid-sequence reset: rst during WAIT_INIT -> all outputs reach reset values next edge. A late init_done is ignored and ready stays 0.
- Retry (macro on, MAX_RETRY=2): init_done never asserted -> init_req pulses exactly 3 times, then fault=1. With the macro off, init_req pulses once, then fault.
